// File: rtl/prog_loader.sv
// Program loader: assembles a big-endian byte stream into 32-bit words, writes them to
// memory at consecutive indices, then releases the CPU reset after a short hold-off.
module prog_loader #(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned RELEASE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   load_len,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned RelW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
   localparam logic [RelW-1:0]     RelLast = RelW'(RELEASE_CYCLES - 1);
   localparam logic [ADDR_WIDTH:0] MaxLen  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] OneW    = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [2:0] {StIdle, StRecv, StWrite, StRelease, StDone} state_e;

   state_e                state_q, state_d;
   logic [31:0]           asm_q, asm_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
   logic [ADDR_WIDTH:0]   len_q, len_d;
   logic [RelW-1:0]       rel_cnt_q, rel_cnt_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  cpu_reset_q, cpu_reset_d;
   logic [ADDR_WIDTH:0]   word_inc;
   logic                  len_ok;

   assign word_inc = word_cnt_q + OneW;
   assign len_ok   = (load_len != '0) && (load_len <= MaxLen);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         asm_q       <= '0;
         byte_cnt_q  <= '0;
         word_cnt_q  <= '0;
         len_q       <= '0;
         rel_cnt_q   <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         cpu_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         asm_q       <= asm_d;
         byte_cnt_q  <= byte_cnt_d;
         word_cnt_q  <= word_cnt_d;
         len_q       <= len_d;
         rel_cnt_q   <= rel_cnt_d;
         done_q      <= done_d;
         error_q     <= error_d;
         cpu_reset_q <= cpu_reset_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      asm_d       = asm_q;
      byte_cnt_d  = byte_cnt_q;
      word_cnt_d  = word_cnt_q;
      len_d       = len_q;
      rel_cnt_d   = rel_cnt_q;
      done_d      = done_q;
      error_d     = error_q;
      cpu_reset_d = cpu_reset_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               if (len_ok) begin
                  state_d     = StRecv;
                  asm_d       = '0;
                  byte_cnt_d  = '0;
                  word_cnt_d  = '0;
                  len_d       = load_len;
                  done_d      = 1'b0;
                  error_d     = 1'b0;
                  cpu_reset_d = 1'b1;
               end else begin
                  // Rejected start leaves cpu_reset and done untouched.
                  state_d = StIdle;
                  error_d = 1'b1;
               end
            end
         end
         StRecv: begin
            if (in_valid) begin
               asm_d      = {asm_q[23:0], in_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) state_d = StWrite;
            end
         end
         StWrite: begin
            word_cnt_d = word_inc;
            if (word_inc < len_q) begin
               state_d = StRecv;
            end else begin
               state_d   = StRelease;
               rel_cnt_d = '0;
            end
         end
         StRelease: begin
            if (rel_cnt_q == RelLast) begin
               state_d     = StDone;
               cpu_reset_d = 1'b0;
               done_d      = 1'b1;
            end else begin
               rel_cnt_d = rel_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready = (state_q == StRecv);
      mem_we   = (state_q == StWrite);
      busy     = (state_q == StRecv) || (state_q == StWrite) || (state_q == StRelease);
   end

   assign mem_addr  = word_cnt_q[ADDR_WIDTH-1:0];
   assign mem_wdata = asm_q;
   assign cpu_reset = cpu_reset_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader with default parameters.
module tb_prog_loader;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW:0]   load_len;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_reset;
   logic          busy;
   logic          done;
   logic          error;

   int checks = 0;
   int errors = 0;
   int nbytes = 0;
   logic [AW+31:0] wlog[$];

   always #5 clk = ~clk;

   prog_loader #(.ADDR_WIDTH(AW), .RELEASE_CYCLES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .load_len  (load_len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   // Every mem_we cycle and every consumed byte is recorded mid-cycle.
   always @(negedge clk) begin
      if (mem_we) wlog.push_back({mem_addr, mem_wdata});
      if (in_valid && in_ready) nbytes++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [AW:0] len);
      start    = 1'b1;
      load_len = len;
      tick();
      start = 1'b0;
   endtask

   task automatic feed_byte(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !in_ready; i++) tick();
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL feed_byte: in_ready=%b required 1 within 20 cycles", in_ready);
      end
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; load_len = '0; in_valid = 1'b0; in_data = '0;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_reset} !==
          {1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state: got rdy=%b we=%b addr=%0d wd=%h busy=%b done=%b err=%b cr=%b",
                  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_reset);
      end
   endtask

   task automatic test_load3();
      logic [7:0]  bytes [12] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07,
                                  8'h01, 8'h09, 8'h10, 8'h20};
      logic [31:0] words [3]  = '{32'h20080005, 32'h20090007, 32'h01091020};
      int base;
      base = wlog.size();
      do_start(11'd3);
      checks++;
      if ({busy, cpu_reset, done, error, in_ready} !== 5'b11001) begin
         errors++;
         $display("FAIL load3_accept: busy/cr/done/err/rdy=%b required 11001",
                  {busy, cpu_reset, done, error, in_ready});
      end
      for (int w = 0; w < 3; w++) begin
         for (int b = 0; b < 4; b++) feed_byte(bytes[w*4+b]);
         checks++;
         if ({mem_we, in_ready, mem_addr, mem_wdata} !== {1'b1, 1'b0, AW'(w), words[w]}) begin
            errors++;
            $display("FAIL load3_write%0d: we=%b rdy=%b addr=%0d data=%h required we=1 rdy=0 addr=%0d data=%h",
                     w, mem_we, in_ready, mem_addr, mem_wdata, w, words[w]);
         end
      end
      for (int r = 0; r < 4; r++) begin
         tick();
         checks++;
         if ({cpu_reset, busy, done, mem_we} !== 4'b1100) begin
            errors++;
            $display("FAIL load3_release%0d: cr/busy/done/we=%b required 1100",
                     r, {cpu_reset, busy, done, mem_we});
         end
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({cpu_reset, busy, done} !== 3'b001) begin
         errors++;
         $display("FAIL load3_done: cr/busy/done=%b required 001", {cpu_reset, busy, done});
      end
      tick(); tick(); tick();
      checks++;
      if ({cpu_reset, busy, done, mem_we} !== 4'b0010) begin
         errors++;
         $display("FAIL load3_hold: cr/busy/done/we=%b required 0010",
                  {cpu_reset, busy, done, mem_we});
      end
      checks++;
      if (wlog.size() - base != 3) begin
         errors++;
         $display("FAIL load3_wcount: got %0d write cycles required 3", wlog.size() - base);
      end else begin
         for (int w = 0; w < 3; w++) begin
            checks++;
            if (wlog[base+w] !== {AW'(w), words[w]}) begin
               errors++;
               $display("FAIL load3_log%0d: got %h required %h", w, wlog[base+w],
                        {AW'(w), words[w]});
            end
         end
      end
   endtask

   task automatic test_stall();
      int         pat [7]   = '{1, 0, 0, 1, 0, 1, 1};
      logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      int base;
      int nb0;
      int k;
      base = wlog.size();
      nb0  = nbytes;
      k    = 0;
      do_start(11'd1);
      for (int i = 0; i < 7; i++) begin
         in_valid = (pat[i] != 0);
         if (pat[i] != 0) begin
            in_data = bytes[k];
            k++;
         end else begin
            in_data = 8'hFF;
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd0, 32'h11223344}) begin
         errors++;
         $display("FAIL stall_write: we=%b addr=%0d data=%h required we=1 addr=0 data=11223344",
                  mem_we, mem_addr, mem_wdata);
      end
      checks++;
      if (nbytes - nb0 != 4) begin
         errors++;
         $display("FAIL stall_bytes: consumed %0d bytes required 4", nbytes - nb0);
      end
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if ({done, busy, cpu_reset} !== 3'b100 || wlog.size() - base != 1) begin
         errors++;
         $display("FAIL stall_done: done/busy/cr=%b writes=%0d required 100 and 1 write",
                  {done, busy, cpu_reset}, wlog.size() - base);
      end
   endtask

   task automatic test_reload();
      do_start(11'd1);
      checks++;
      if ({done, cpu_reset, busy} !== 3'b011) begin
         errors++;
         $display("FAIL reload_accept: done/cr/busy=%b required 011", {done, cpu_reset, busy});
      end
      feed_byte(8'hDE); feed_byte(8'hAD); feed_byte(8'hBE); feed_byte(8'hEF);
      in_valid = 1'b0;
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd0, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL reload_write: we=%b addr=%0d data=%h required we=1 addr=0 data=deadbeef",
                  mem_we, mem_addr, mem_wdata);
      end
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if ({done, cpu_reset} !== 2'b10) begin
         errors++;
         $display("FAIL reload_done: done/cr=%b required 10", {done, cpu_reset});
      end
   endtask

   task automatic test_ignored_start();
      int base;
      base = wlog.size();
      do_start(11'd2);
      feed_byte(8'h01); feed_byte(8'h02);
      in_valid = 1'b0;
      start    = 1'b1;
      load_len = 11'd1;
      tick();
      start = 1'b0;
      checks++;
      if ({busy, error, in_ready} !== 3'b101) begin
         errors++;
         $display("FAIL ign_start_state: busy/err/rdy=%b required 101", {busy, error, in_ready});
      end
      feed_byte(8'h03); feed_byte(8'h04);
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd0, 32'h01020304}) begin
         errors++;
         $display("FAIL ign_start_w0: we=%b addr=%0d data=%h required we=1 addr=0 data=01020304",
                  mem_we, mem_addr, mem_wdata);
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if ({in_ready, busy} !== 2'b11) begin
         errors++;
         $display("FAIL ign_start_len: rdy/busy=%b required 11 (load_len re-sampled)",
                  {in_ready, busy});
      end
      feed_byte(8'h05); feed_byte(8'h06); feed_byte(8'h07); feed_byte(8'h08);
      in_valid = 1'b0;
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd1, 32'h05060708}) begin
         errors++;
         $display("FAIL ign_start_w1: we=%b addr=%0d data=%h required we=1 addr=1 data=05060708",
                  mem_we, mem_addr, mem_wdata);
      end
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (done !== 1'b1 || wlog.size() - base != 2) begin
         errors++;
         $display("FAIL ign_start_done: done=%b writes=%0d required done=1 and 2 writes",
                  done, wlog.size() - base);
      end
   endtask

   task automatic test_bad_len();
      int base;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      base = wlog.size();
      do_start(11'd0);
      checks++;
      if ({error, busy, mem_we, cpu_reset, done, in_ready} !== 6'b100100) begin
         errors++;
         $display("FAIL bad_len0: err/busy/we/cr/done/rdy=%b required 100100",
                  {error, busy, mem_we, cpu_reset, done, in_ready});
      end
      do_start(11'd1025);
      checks++;
      if ({error, busy, mem_we, cpu_reset, done, in_ready} !== 6'b100100) begin
         errors++;
         $display("FAIL bad_len1025: err/busy/we/cr/done/rdy=%b required 100100",
                  {error, busy, mem_we, cpu_reset, done, in_ready});
      end
      tick(); tick(); tick();
      checks++;
      if (wlog.size() != base || busy !== 1'b0 || error !== 1'b1) begin
         errors++;
         $display("FAIL bad_len_idle: writes=%0d busy=%b err=%b required 0 writes busy=0 err=1",
                  wlog.size() - base, busy, error);
      end
      do_start(11'd1024);
      checks++;
      if ({error, busy, in_ready} !== 3'b011) begin
         errors++;
         $display("FAIL max_len_accept: err/busy/rdy=%b required 011", {error, busy, in_ready});
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_midload_reset();
      int base;
      base = wlog.size();
      do_start(11'd2);
      feed_byte(8'hA0); feed_byte(8'hA1); feed_byte(8'hA2); feed_byte(8'hA3);
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd0, 32'hA0A1A2A3}) begin
         errors++;
         $display("FAIL midrst_w0: we=%b addr=%0d data=%h required we=1 addr=0 data=a0a1a2a3",
                  mem_we, mem_addr, mem_wdata);
      end
      feed_byte(8'hA4); feed_byte(8'hA5);
      reset   = 1'b1;
      in_data = 8'hA6;
      tick();
      reset = 1'b0;
      checks++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_reset} !==
          {1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL midrst_state: rdy=%b we=%b addr=%0d wd=%h busy=%b done=%b err=%b cr=%b",
                  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_reset);
      end
      for (int i = 0; i < 10; i++) begin
         in_data = 8'hB0 + 8'(i);
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (wlog.size() - base != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_nowrite: writes=%0d busy=%b required 1 write busy=0",
                  wlog.size() - base, busy);
      end
      reset    = 1'b1;
      start    = 1'b1;
      load_len = 11'd1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      tick();
      checks++;
      if ({busy, cpu_reset, error, in_ready} !== 4'b0100) begin
         errors++;
         $display("FAIL reset_over_start: busy/cr/err/rdy=%b required 0100",
                  {busy, cpu_reset, error, in_ready});
      end
   endtask

   initial begin
      test_reset();
      test_load3();
      test_stall();
      test_reload();
      test_ignored_start();
      test_bad_len();
      test_midload_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
